fd_hazard_pipe: RTL and testbench

- IF/ID pipeline register plus hazard controller. Sits between fetch and decode, directly upstream of the DX pipeline register.
- Captures the fetched instruction and PC+2, and generates the PC write-enable and a DX bubble request.
- Handles load-use stalls, branch/jump flushes resolved in X, instruction-memory stalls and HALT freeze.
- Keeps a saturating stall-cycle counter.

---
 rtl/fd_hazard_pipe.sv | 157 +++++++++++++++
 tb/tb_fd_hazard_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fd_hazard_pipe.sv
// fd_hazard_pipe
// IF/ID pipeline register and hazard controller. It sits between fetch and
// decode and feeds the DX pipeline register. It captures the fetched
// instruction and PC+2, and drives the PC write-enable and a DX bubble
// request. It handles load-use stalls, redirects resolved in X,
// instruction-memory stalls and the HALT freeze. It also keeps a saturating
// count of stall cycles.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   if_instr       instruction from fetch
//   if_pc_inc      PC+2 from fetch
//   imem_stall     fetch data not ready this cycle
//   x_redirect     taken branch/jump resolved in X this cycle
//   dx_memRead     instruction in DX is a load
//   dx_regWrite    instruction in DX writes the register file
//   dx_writeReg    destination register of the instruction in DX
//   dec_usesRs     decoded FD_instr reads Rs (FD_instr[10:8])
//   dec_usesRt     decoded FD_instr reads Rt (FD_instr[7:5])
//   FD_instr       registered instruction to decode
//   FD_pc_inc      registered PC+2
//   FD_valid       FD holds a real instruction
//   pc_write       PC update enable (combinational)
//   dx_bubble      zero the DX control signals at the next edge (combinational)
//   halted         registered HALT state indicator
//   stall_cycles   saturating count of load-use and imem stall cycles
module fd_hazard_pipe #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OP   = 5'b00000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      if_instr,
  input  logic [15:0]      if_pc_inc,
  input  logic             imem_stall,
  input  logic             x_redirect,
  input  logic             dx_memRead,
  input  logic             dx_regWrite,
  input  logic [2:0]       dx_writeReg,
  input  logic             dec_usesRs,
  input  logic             dec_usesRt,
  output logic [15:0]      FD_instr,
  output logic [15:0]      FD_pc_inc,
  output logic             FD_valid,
  output logic             pc_write,
  output logic             dx_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t state;

  logic lu_haz;
  logic is_halt;
  logic take_lu;
  logic cnt_inc;

  // A load in DX whose destination matches a source that the instruction in FD
  // actually reads. Only one bubble is ever needed. After one cycle the load is
  // in XM and forwarding covers it, so LU_STALL ignores the hazard.
  always_comb begin
    lu_haz  = FD_valid & dx_memRead & dx_regWrite &
              ((dec_usesRs & (FD_instr[10:8] == dx_writeReg)) |
               (dec_usesRt & (FD_instr[7:5]  == dx_writeReg)));
    is_halt = FD_valid & (FD_instr[15:11] == HALT_OP);
    take_lu = lu_haz & (state == RUN);
  end

  // The priority is redirect, then HALT (current state or decoded), then
  // load-use, then imem stall, then normal. A redirect lets the PC load the
  // target and squashes whatever is in FD. HALT lets itself drain into DX but
  // stops the PC. An imem stall only holds the PC. The FD instruction still
  // advances.
  always_comb begin
    pc_write  = 1'b0;
    dx_bubble = 1'b0;
    cnt_inc   = 1'b0;
    if (rst) begin
      pc_write  = 1'b0;
      dx_bubble = 1'b0;
    end else if (x_redirect) begin
      pc_write  = 1'b1;
      dx_bubble = 1'b1;
    end else if (state == HALT || is_halt) begin
      pc_write  = 1'b0;
    end else if (take_lu) begin
      dx_bubble = 1'b1;
      cnt_inc   = 1'b1;
    end else if (imem_stall) begin
      cnt_inc   = 1'b1;
    end else begin
      pc_write  = 1'b1;
    end
  end

  // FD register and the control FSM. The stall and HALT branches leave
  // FD_pc_inc untouched. Its value only matters while FD_valid is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FD_instr  <= NOP_INSTR;
      FD_pc_inc <= '0;
      FD_valid  <= 1'b0;
      state     <= RUN;
      halted    <= 1'b0;
    end else if (x_redirect) begin
      FD_instr  <= NOP_INSTR;
      FD_pc_inc <= '0;
      FD_valid  <= 1'b0;
      state     <= RUN;
      halted    <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          FD_instr <= NOP_INSTR;
          FD_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          if (is_halt) begin
            FD_instr <= NOP_INSTR;
            FD_valid <= 1'b0;
            state    <= HALT;
            halted   <= 1'b1;
          end else if (take_lu) begin
            state    <= LU_STALL;
          end else if (imem_stall) begin
            FD_instr <= NOP_INSTR;
            FD_valid <= 1'b0;
            state    <= RUN;
          end else begin
            FD_instr  <= if_instr;
            FD_pc_inc <= if_pc_inc;
            FD_valid  <= 1'b1;
            state     <= RUN;
          end
        end
      endcase
    end
  end

  // The stall counter stops at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (cnt_inc && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fd_hazard_pipe.sv
// tb_fd_hazard_pipe
// Self-checking bench for fd_hazard_pipe. A rule-level model of the FD
// register is compared with two DUT instances every cycle. One instance has a
// 16-bit stall counter and the other a 2-bit counter, so saturation gets
// exercised. Directed scenarios pin the model with literal values. A long run
// of random stimulus follows.
module tb_fd_hazard_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_instr, if_pc_inc;
  logic        imem_stall, x_redirect, dx_memRead, dx_regWrite;
  logic [2:0]  dx_writeReg;
  logic        dec_usesRs, dec_usesRt;

  logic [15:0] a_instr, a_pc;
  logic        a_valid, a_pw, a_db, a_halted;
  logic [15:0] a_cnt;
  logic [15:0] b_instr, b_pc;
  logic        b_valid, b_pw, b_db, b_halted;
  logic [1:0]  b_cnt;

  int total = 0;
  int passed = 0;

  // Model state, kept in terms of rules rather than registers.
  logic [15:0] m_instr, m_pc;
  logic        m_valid, m_halt, m_after_lu, m_pc_known;
  int          m_cnt;

  fd_hazard_pipe #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc_inc(if_pc_inc),
    .imem_stall(imem_stall), .x_redirect(x_redirect), .dx_memRead(dx_memRead),
    .dx_regWrite(dx_regWrite), .dx_writeReg(dx_writeReg),
    .dec_usesRs(dec_usesRs), .dec_usesRt(dec_usesRt),
    .FD_instr(a_instr), .FD_pc_inc(a_pc), .FD_valid(a_valid),
    .pc_write(a_pw), .dx_bubble(a_db), .halted(a_halted), .stall_cycles(a_cnt)
  );

  fd_hazard_pipe #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc_inc(if_pc_inc),
    .imem_stall(imem_stall), .x_redirect(x_redirect), .dx_memRead(dx_memRead),
    .dx_regWrite(dx_regWrite), .dx_writeReg(dx_writeReg),
    .dec_usesRs(dec_usesRs), .dec_usesRt(dec_usesRt),
    .FD_instr(b_instr), .FD_pc_inc(b_pc), .FD_valid(b_valid),
    .pc_write(b_pw), .dx_bubble(b_db), .halted(b_halted), .stall_cycles(b_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req)
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    else
      passed++;
  endfunction

  function automatic void model_reset();
    m_instr    = 16'h0800;
    m_pc       = 16'h0000;
    m_valid    = 1'b0;
    m_halt     = 1'b0;
    m_after_lu = 1'b0;
    m_pc_known = 1'b1;
    m_cnt      = 0;
  endfunction

  // Event codes: 0 reset, 1 redirect, 2 halted, 3 HALT in FD, 4 load-use,
  // 5 imem stall, 6 normal.
  function automatic int classify();
    logic haz;
    haz = m_valid && dx_memRead && dx_regWrite &&
          ((dec_usesRs && m_instr[10:8] == dx_writeReg) ||
           (dec_usesRt && m_instr[7:5] == dx_writeReg));
    if (rst)                                  return 0;
    if (x_redirect)                           return 1;
    if (m_halt)                               return 2;
    if (m_valid && m_instr[15:11] == 5'd0)    return 3;
    if (haz && !m_after_lu)                   return 4;
    if (imem_stall)                           return 5;
    return 6;
  endfunction

  function automatic void model_commit(int ev, logic [15:0] ins, logic [15:0] pci);
    case (ev)
      0: model_reset();
      1: begin m_instr = 16'h0800; m_pc = 0; m_pc_known = 1; m_valid = 0; m_halt = 0; m_after_lu = 0; end
      2: begin m_instr = 16'h0800; m_valid = 0; m_pc_known = 0; end
      3: begin m_instr = 16'h0800; m_valid = 0; m_pc_known = 0; m_halt = 1; m_after_lu = 0; end
      4: begin m_after_lu = 1; m_cnt++; end
      5: begin m_instr = 16'h0800; m_valid = 0; m_pc_known = 0; m_after_lu = 0; m_cnt++; end
      default: begin m_instr = ins; m_pc = pci; m_pc_known = 1; m_valid = 1; m_after_lu = 0; end
    endcase
  endfunction

  task automatic checkOutput(input int ev);
    logic epw, edb;
    int   ca, cb;
    epw = (ev == 1 || ev == 6);
    edb = (ev == 1 || ev == 4);
    ca  = (m_cnt > 65535) ? 65535 : m_cnt;
    cb  = (m_cnt > 3) ? 3 : m_cnt;
    check("a_instr", a_instr, m_instr);
    check("a_valid", a_valid, m_valid);
    check("a_halted", a_halted, m_halt);
    check("a_pc_write", a_pw, epw);
    check("a_dx_bubble", a_db, edb);
    check("a_stall_cycles", a_cnt, ca);
    if (m_valid || m_pc_known) check("a_pc_inc", a_pc, m_pc);
    check("b_instr", b_instr, m_instr);
    check("b_valid", b_valid, m_valid);
    check("b_halted", b_halted, m_halt);
    check("b_pc_write", b_pw, epw);
    check("b_dx_bubble", b_db, edb);
    check("b_stall_cycles", b_cnt, cb);
  endtask

  // Drive one cycle of inputs at the falling edge, compare just after, then
  // advance the model across the rising edge.
  task automatic applyStimulus(input logic r, red, ims, mr, rw, input logic [2:0] wr,
                               input logic urs, urt, input logic [15:0] ins, pci,
                               output logic pw, output logic db);
    int ev;
    @(negedge clk);
    rst = r; x_redirect = red; imem_stall = ims; dx_memRead = mr; dx_regWrite = rw;
    dx_writeReg = wr; dec_usesRs = urs; dec_usesRt = urt; if_instr = ins; if_pc_inc = pci;
    #1;
    if (r) model_reset();
    ev = classify();
    checkOutput(ev);
    pw = a_pw;
    db = a_db;
    @(posedge clk);
    model_commit(ev, ins, pci);
    #1;
  endtask

  initial begin
    logic pw, db;
    logic r, red, ims, mr, rw, urs, urt;
    logic [2:0]  wr;
    logic [15:0] ins;
    rst = 1'b1; x_redirect = 0; imem_stall = 0; dx_memRead = 0; dx_regWrite = 0;
    dx_writeReg = 0; dec_usesRs = 0; dec_usesRt = 0; if_instr = 0; if_pc_inc = 0;
    model_reset();

    applyStimulus(1, 0, 0, 0, 0, 3'd0, 0, 0, 16'h0000, 16'h0000, pw, db);
    check("reset_pc_write", pw, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'hC140, 16'h0004, pw, db);
    check("first_capture", a_instr, 16'hC140);

    // Reset in the middle of a cycle while FD holds a valid instruction.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_instr", a_instr, 16'h0800);
    check("async_rst_valid", a_valid, 1'b0);
    check("async_rst_halted", a_halted, 1'b0);
    check("async_rst_cnt", a_cnt, 16'd0);
    checkOutput(0);
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'h4125, 16'h0002, pw, db);
    check("post_rst_instr", a_instr, 16'h4125);
    check("post_rst_pc", a_pc, 16'h0002);
    check("post_rst_valid", a_valid, 1'b1);

    // Load-use on Rs gives exactly one bubble.
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'hC140, 16'h0004, pw, db);
    applyStimulus(0, 0, 0, 1, 1, 3'd1, 1, 0, 16'h2222, 16'h0006, pw, db);
    check("lu_bubble", db, 1'b1);
    check("lu_pc_write", pw, 1'b0);
    check("lu_hold", a_instr, 16'hC140);
    check("lu_cnt", a_cnt, 16'd1);
    applyStimulus(0, 0, 0, 1, 1, 3'd1, 1, 0, 16'h3333, 16'h0008, pw, db);
    check("lu_second_bubble", db, 1'b0);
    check("lu_second_capture", a_instr, 16'h3333);

    // Destination 2 matches only the Rt field of C140.
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'hC140, 16'h000A, pw, db);
    applyStimulus(0, 0, 0, 1, 1, 3'd2, 1, 0, 16'hC140, 16'h000C, pw, db);
    check("rt_unused_bubble", db, 1'b0);
    applyStimulus(0, 0, 0, 1, 1, 3'd2, 1, 1, 16'hC140, 16'h000E, pw, db);
    check("rt_used_bubble", db, 1'b1);
    check("rt_cnt", a_cnt, 16'd2);

    // A redirect beats load-use and imem stall together.
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'hC140, 16'h0010, pw, db);
    applyStimulus(0, 1, 1, 1, 1, 3'd1, 1, 0, 16'h5555, 16'h0012, pw, db);
    check("redir_bubble", db, 1'b1);
    check("redir_pc_write", pw, 1'b1);
    check("redir_instr", a_instr, 16'h0800);
    check("redir_valid", a_valid, 1'b0);
    check("redir_cnt", a_cnt, 16'd2);

    // HALT freezes the PC until a redirect arrives.
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'h0000, 16'h0014, pw, db);
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'h1111, 16'h0016, pw, db);
    check("halt_pc_write", pw, 1'b0);
    check("halt_halted", a_halted, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'h1111, 16'h0016, pw, db);
      check("halt_hold_pw", pw, 1'b0);
      check("halt_hold_instr", a_instr, 16'h0800);
    end
    applyStimulus(0, 1, 0, 0, 0, 3'd0, 0, 0, 16'h1111, 16'h0016, pw, db);
    check("halt_exit_pw", pw, 1'b1);
    check("halt_exit_halted", a_halted, 1'b0);

    // imem stalls count up and saturate in the 2-bit instance.
    applyStimulus(1, 0, 0, 0, 0, 3'd0, 0, 0, 16'h0000, 16'h0000, pw, db);
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'h4125, 16'h0002, pw, db);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 1, 0, 0, 3'd0, 0, 0, 16'h6666, 16'h0004, pw, db);
    check("imem_instr", a_instr, 16'h0800);
    check("imem_valid", a_valid, 1'b0);
    check("imem_cnt_a", a_cnt, 16'd3);
    check("imem_cnt_b", b_cnt, 2'd3);
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 0, 1, 0, 0, 3'd0, 0, 0, 16'h6666, 16'h0004, pw, db);
    check("sat_cnt_a", a_cnt, 16'd5);
    check("sat_cnt_b", b_cnt, 2'd3);

    // Random traffic, biased toward hazards, HALTs and redirects.
    for (int n = 0; n < 4000; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      red = ($urandom_range(0, 9) == 0);
      ims = ($urandom_range(0, 4) == 0);
      mr  = ($urandom_range(0, 2) != 0);
      rw  = ($urandom_range(0, 3) != 0);
      urs = $urandom_range(0, 1);
      urt = $urandom_range(0, 1);
      wr  = $urandom_range(0, 1) ? m_instr[10:8] : 3'($urandom_range(0, 7));
      ins = 16'($urandom);
      if ($urandom_range(0, 14) == 0) ins[15:11] = 5'd0;
      applyStimulus(r, red, ims, mr, rw, wr, urs, urt, ins, 16'($urandom), pw, db);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
